// File: rtl/pdm_sample_sched.sv
// rtl/pdm_sample_sched.sv - sample FIFO, ce divider and oversampling sequencer for the PDM modulator
module pdm_sample_sched #(
    parameter int INPUT_WIDTH = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int OSR_WIDTH   = 8,
    parameter int FIFO_AW     = 2
) (
    input  logic                   i_clk,
    input  logic                   i_res,
    input  logic                   i_enable,
    input  logic [DIV_WIDTH-1:0]   i_ce_div,
    input  logic [OSR_WIDTH-1:0]   i_osr,
    input  logic [INPUT_WIDTH-1:0] i_s_data,
    input  logic                   i_s_valid,
    output logic                   o_s_ready,
    output logic                   o_ce,
    output logic [INPUT_WIDTH-1:0] o_func,
    output logic                   o_mod_res,
    output logic [FIFO_AW:0]       o_level,
    output logic                   o_underrun,
    input  logic                   i_underrun_clr
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] L_DEPTH = (FIFO_AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]             r_state;
    logic [DIV_WIDTH-1:0]   r_div_l;
    logic [OSR_WIDTH-1:0]   r_osr_l;
    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic [OSR_WIDTH-1:0]   r_smp_cnt;
    logic [INPUT_WIDTH-1:0] r_func;
    logic                   r_ce;
    logic                   r_mod_res;
    logic                   r_ready;
    logic [FIFO_AW:0]       r_level;
    logic                   r_underrun;
    logic [FIFO_AW-1:0]     r_wr_ptr;
    logic [FIFO_AW-1:0]     r_rd_ptr;
    logic [INPUT_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [1:0]             w_state_next;
    logic [DIV_WIDTH-1:0]   w_div_next;
    logic [OSR_WIDTH-1:0]   w_smp_next;
    logic [INPUT_WIDTH-1:0] w_func_next;
    logic                   w_pop_req;
    logic                   w_boundary;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_underrun_set;
    logic                   w_ce_next;
    logic                   w_empty;
    logic [INPUT_WIDTH-1:0] w_head;
    logic [FIFO_AW:0]       w_level_next;

    assign w_empty        = (r_level == '0);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_push         = i_s_valid && r_ready;
    assign w_pop          = w_pop_req && !w_empty;
    assign w_underrun_set = w_boundary && w_empty;
    // r_ce always mirrors "divider at terminal count while running" for the coming cycle
    assign w_ce_next      = (w_state_next == ST_RUN) && (w_div_next == r_div_l);

    // Next-state, divider, sample counter and modulator input selection
    always_comb begin
        w_state_next = r_state;
        w_div_next   = '0;
        w_smp_next   = '0;
        w_func_next  = r_func;
        w_pop_req    = 1'b0;
        w_boundary   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_func_next = '0;
                if (i_enable) begin
                    w_state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                    w_func_next  = '0;
                end else if (!w_empty) begin
                    w_pop_req    = 1'b1;
                    w_func_next  = w_head;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    // Disable wins over a coinciding boundary so the FIFO is left untouched
                    w_state_next = ST_IDLE;
                    w_func_next  = '0;
                end else begin
                    w_div_next = (r_div_cnt == r_div_l) ? '0 : r_div_cnt + 1'b1;
                    w_smp_next = r_smp_cnt;
                    if (r_ce) begin
                        if (r_smp_cnt == r_osr_l) begin
                            w_boundary = 1'b1;
                            w_smp_next = '0;
                        end else begin
                            w_smp_next = r_smp_cnt + 1'b1;
                        end
                    end
                    if (w_boundary) begin
                        w_pop_req   = 1'b1;
                        w_func_next = w_empty ? '0 : w_head;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_func_next  = '0;
            end
        endcase
    end

    // FIFO occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // FIFO storage; pointers alone define validity so the array needs no reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_s_data;
        end
    end

    // Control state, counters and registered outputs
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state    <= ST_IDLE;
            r_div_l    <= '0;
            r_osr_l    <= '0;
            r_div_cnt  <= '0;
            r_smp_cnt  <= '0;
            r_func     <= '0;
            r_ce       <= 1'b0;
            r_mod_res  <= 1'b1;
            r_ready    <= 1'b0;
            r_level    <= '0;
            r_underrun <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_next;
            r_smp_cnt <= w_smp_next;
            r_func    <= w_func_next;
            r_ce      <= w_ce_next;
            r_mod_res <= (w_state_next != ST_RUN);
            r_level   <= w_level_next;
            r_ready   <= (w_level_next < L_DEPTH);
            if (r_state == ST_IDLE && i_enable) begin
                r_div_l <= i_ce_div;
                r_osr_l <= i_osr;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (i_underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign o_s_ready  = r_ready;
    assign o_ce       = r_ce;
    assign o_func     = r_func;
    assign o_mod_res  = r_mod_res;
    assign o_level    = r_level;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_pdm_sample_sched.sv
// tb/tb_pdm_sample_sched.sv - self-checking bench for pdm_sample_sched
module tb_pdm_sample_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] ce_div;
    logic [7:0]  osr;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ce;
    logic [7:0]  func;
    logic        mod_res;
    logic [2:0]  level;
    logic        under;
    logic        clr;

    int n_checks;
    int n_errors;

    pdm_sample_sched dut (
        .i_clk         (clk),
        .i_res         (rst),
        .i_enable      (en),
        .i_ce_div      (ce_div),
        .i_osr         (osr),
        .i_s_data      (s_data),
        .i_s_valid     (s_valid),
        .o_s_ready     (s_ready),
        .o_ce          (ce),
        .o_func        (func),
        .o_mod_res     (mod_res),
        .o_level       (level),
        .o_underrun    (under),
        .i_underrun_clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        s_valid = 1'b0;
        clr     = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Behavioural reference: mode 0 idle, 1 prime, 2 run; k = cycles in run, t = ticks in run
    int         m_mode, m_k, m_t, m_div, m_osr;
    logic [7:0] m_func;
    logic       m_ready, m_under;
    logic [7:0] m_q[$];

    function automatic logic m_ce();
        return (m_mode == 2) && ((m_k % (m_div + 1)) == m_div);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_t = 0; m_div = 0; m_osr = 0;
        m_func = 8'h00; m_ready = 1'b0; m_under = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic push, set_u, tick;
        push  = s_valid && m_ready;
        set_u = 1'b0;
        tick  = m_ce();
        case (m_mode)
            0: begin
                m_func = 8'h00;
                if (en) begin
                    m_mode = 1;
                    m_div  = int'(ce_div);
                    m_osr  = int'(osr);
                end
            end
            1: begin
                if (!en) begin
                    m_mode = 0;
                    m_func = 8'h00;
                end else if (m_q.size() > 0) begin
                    m_func = m_q.pop_front();
                    m_mode = 2;
                    m_k    = 0;
                    m_t    = 0;
                end
            end
            default: begin
                if (!en) begin
                    m_mode = 0;
                    m_func = 8'h00;
                end else begin
                    if (tick) begin
                        if ((m_t % (m_osr + 1)) == m_osr) begin
                            if (m_q.size() > 0) begin
                                m_func = m_q.pop_front();
                            end else begin
                                m_func = 8'h00;
                                set_u  = 1'b1;
                            end
                        end
                        m_t++;
                    end
                    m_k++;
                end
            end
        endcase
        if (push) m_q.push_back(s_data);
        if (set_u) m_under = 1'b1;
        else if (clr) m_under = 1'b0;
        m_ready = (m_q.size() < 4);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic [2:0] lvl;
        logic       rdy;
        logic       mr;
        logic [7:0] f;
        logic       c;
    } vec_t;

    vec_t tbl[9];

    function automatic int exp_rate(input int t);
        if (t < 4) return 32'h10;
        if (t < 8) return 32'h20;
        if (t < 12) return 32'h30;
        return 0;
    endfunction

    initial begin
        int run_cyc, ticks, prev;
        logic found;
        n_checks = 0;
        n_errors = 0;

        //           v     d      e     lvl   rdy   mr    f      c
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'hA2, 1'b0, 3'd2, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 8'hA3, 1'b0, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'hA4, 1'b0, 3'd4, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 8'hA5, 1'b0, 3'd4, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 8'hA1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0};

        rst = 1'b1; en = 1'b0; ce_div = 16'd0; osr = 8'd0;
        s_data = 8'h00; s_valid = 1'b0; clr = 1'b0;
        step();
        chk("rst_ce", int'(ce), 0);
        chk("rst_func", int'(func), 0);
        chk("rst_mod_res", int'(mod_res), 1);
        chk("rst_ready", int'(s_ready), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_underrun", int'(under), 0);
        rst = 1'b0;
        step();
        chk("ready_after_release", int'(s_ready), 1);

        // Fill to full, prime, one pop, disable
        ce_div = 16'd5; osr = 8'd2;
        for (int i = 0; i < 9; i++) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].d;
            en      = tbl[i].e;
            step();
            chk($sformatf("tbl%0d_level", i), int'(level), int'(tbl[i].lvl));
            chk($sformatf("tbl%0d_ready", i), int'(s_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_mod_res", i), int'(mod_res), int'(tbl[i].mr));
            chk($sformatf("tbl%0d_func", i), int'(func), int'(tbl[i].f));
            chk($sformatf("tbl%0d_ce", i), int'(ce), int'(tbl[i].c));
        end
        s_valid = 1'b0;

        // Rate, sample hold, underrun, clear and set-over-clear priority
        do_reset();
        s_valid = 1'b1;
        s_data = 8'h10; step();
        s_data = 8'h20; step();
        s_data = 8'h30; step();
        s_valid = 1'b0;
        ce_div = 16'd3; osr = 8'd3; en = 1'b1;
        step();
        chk("rate_prime_mod_res", int'(mod_res), 1);
        step();
        chk("rate_run_mod_res", int'(mod_res), 0);
        chk("rate_first_func", int'(func), 32'h10);
        run_cyc = 0; ticks = 0; prev = -1;
        for (int n = 0; n < 200 && ticks < 13; n++) begin
            if (n == 5) ce_div = 16'd0;
            if (ce) begin
                chk($sformatf("rate_tick%0d_func", ticks), int'(func), exp_rate(ticks));
                if (prev < 0) chk("rate_first_ce", run_cyc, 3);
                else chk($sformatf("rate_tick%0d_period", ticks), run_cyc - prev, 4);
                prev = run_cyc;
                ticks++;
            end
            step();
            run_cyc++;
        end
        chk("rate_tick_count", ticks, 13);
        chk("underrun_set", int'(under), 1);
        chk("underrun_func", int'(func), 0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("underrun_clr", int'(under), 0);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (ce && (ticks % 4) == 3) begin
                clr = 1'b1; step(); clr = 1'b0;
                chk("underrun_priority", int'(under), 1);
                found = 1'b1;
            end else begin
                if (ce) ticks++;
                step();
            end
        end
        chk("underrun_boundary_found", int'(found), 1);
        en = 1'b0;

        // Disable mid-sample, then config takes effect only on the next enable
        do_reset();
        s_valid = 1'b1;
        s_data = 8'h55; step();
        s_data = 8'h66; step();
        s_valid = 1'b0;
        ce_div = 16'd1; osr = 8'd7; en = 1'b1;
        step(); step();
        chk("dis_run_func", int'(func), 32'h55);
        chk("dis_run_level", int'(level), 1);
        step(); step(); step();
        en = 1'b0;
        step();
        chk("dis_mod_res", int'(mod_res), 1);
        chk("dis_ce", int'(ce), 0);
        chk("dis_func", int'(func), 0);
        chk("dis_level", int'(level), 1);
        step();
        chk("dis_ce_stays", int'(ce), 0);
        ce_div = 16'd0; en = 1'b1;
        step(); step();
        chk("reen_func", int'(func), 32'h66);
        chk("reen_ce_k0", int'(ce), 1);
        step();
        chk("reen_ce_k1", int'(ce), 1);
        en = 1'b0;

        // Prime waits on an empty FIFO
        do_reset();
        ce_div = 16'd0; osr = 8'd0; en = 1'b1;
        step();
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("prime%0d_mod_res", n), int'(mod_res), 1);
            chk($sformatf("prime%0d_ce", n), int'(ce), 0);
            step();
        end
        s_valid = 1'b1; s_data = 8'h7F;
        step();
        s_valid = 1'b0;
        chk("prime_push_level", int'(level), 1);
        chk("prime_push_mod_res", int'(mod_res), 1);
        step();
        chk("prime_run_func", int'(func), 32'h7F);
        chk("prime_run_mod_res", int'(mod_res), 0);
        chk("prime_run_ce", int'(ce), 1);
        chk("prime_run_level", int'(level), 0);
        en = 1'b0;

        // Asynchronous reset in the middle of RUN
        do_reset();
        s_valid = 1'b1;
        s_data = 8'h11; step();
        s_data = 8'h22; step();
        s_data = 8'h33; step();
        s_valid = 1'b0;
        ce_div = 16'd0; osr = 8'd3; en = 1'b1;
        step(); step();
        chk("arst_pre_level", int'(level), 2);
        chk("arst_pre_ce", int'(ce), 1);
        #2;
        rst = 1'b1; en = 1'b0;
        #1;
        chk("arst_ce", int'(ce), 0);
        chk("arst_mod_res", int'(mod_res), 1);
        chk("arst_func", int'(func), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_ready", int'(s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_ready_at_release", int'(s_ready), 0);
        step();
        chk("arst_ready_after", int'(s_ready), 1);

        // Randomised run against the behavioural model
        rst = 1'b1; en = 1'b1; s_valid = 1'b0; clr = 1'b0;
        step();
        model_reset();
        rst = 1'b0;
        for (int n = 0; n < 3000 && n_errors < 50; n++) begin
            chk("rnd_ce", int'(ce), int'(m_ce()));
            chk("rnd_func", int'(func), int'(m_func));
            chk("rnd_mod_res", int'(mod_res), (m_mode != 2) ? 1 : 0);
            chk("rnd_ready", int'(s_ready), int'(m_ready));
            chk("rnd_level", int'(level), m_q.size());
            chk("rnd_underrun", int'(under), int'(m_under));
            if ($urandom_range(0, 19) == 0) en = !en;
            s_valid = ($urandom_range(0, 1) == 1);
            s_data  = 8'($urandom());
            clr     = ($urandom_range(0, 15) == 0);
            ce_div  = 16'($urandom_range(0, 3));
            osr     = 8'($urandom_range(0, 3));
            model_step();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pdm_sample_sched.md
# pdm_sample_sched

Sample scheduler and rate controller for the second-order sigma-delta PDM DAC. Buffers incoming signed samples from a valid/ready stream in a small FIFO, generates the modulator clock-enable strobe from a programmable divider, and presents each sample to the modulator for exactly a programmed number of modulator ticks (oversampling ratio). It also sequences the modulator's reset around enable/disable and reports FIFO level and underruns.

## Interface
- INPUT_WIDTH, 8, sample width; matches modulator input
- DIV_WIDTH, 16, width of ce divider
- OSR_WIDTH, 8, width of oversampling count
- FIFO_AW, 2, FIFO depth = 2**FIFO_AW words
- i_clk  in  1  system clock
- i_res  in  1  reset, asynchronous, active-high
- i_enable  in  1  run request (level)
- i_ce_div  in  DIV_WIDTH  o_ce period minus 1, in i_clk cycles
- i_osr  in  OSR_WIDTH  modulator ticks per sample minus 1
- i_s_data  in  INPUT_WIDTH  signed two's-complement sample
- i_s_valid  in  1  sample valid
- o_s_ready  out  1  FIFO can accept; transfer when valid & ready
- o_ce  out  1  modulator clock enable, one-cycle pulse
- o_func  out  INPUT_WIDTH  sample to modulator
- o_mod_res  out  1  modulator synchronous reset
- o_level  out  FIFO_AW+1  FIFO occupancy
- o_underrun  out  1  sticky underrun flag
- i_underrun_clr  in  1  clears o_underrun (pulse)

## Operation
- States: IDLE, PRIME, RUN. Reset -> IDLE.
- IDLE: o_ce=0, o_mod_res=1, o_func=0, divider and sample counters held at 0. FIFO still accepts pushes (prefill). i_enable=1 -> PRIME; i_ce_div and i_osr latched on this transition; ignored otherwise.
- PRIME: o_mod_res=1, o_ce=0. When FIFO non-empty: pop head into o_func, -> RUN. i_enable=0 -> IDLE.
- RUN: o_mod_res=0. Divider counts 0..div_l; o_ce=1 in the cycle the divider equals div_l, then divider wraps to 0. Sample counter advances on each o_ce, 0..osr_l.
- Sample boundary: cycle with o_ce=1 and sample counter = osr_l. At end of that cycle sample counter -> 0 and FIFO popped into o_func; the tick in that cycle still uses the old o_func. Each sample therefore drives exactly osr_l+1 ticks.
- Underrun: FIFO empty at a sample boundary -> o_func <= 0, o_underrun <= 1; state stays RUN. Set has priority over simultaneous i_underrun_clr.
- i_enable=0 in RUN -> IDLE next cycle; o_func cleared, FIFO contents retained.
- FIFO: push when i_s_valid & o_s_ready. Push and pop in same cycle both take effect, o_level unchanged. Pop from empty FIFO on the same cycle as a push is an underrun (no bypass); pushed word is stored.

## Timing
- Reset values: o_ce=0, o_func=0, o_mod_res=1, o_s_ready=0, o_level=0, o_underrun=0. o_s_ready rises first cycle after reset release.
- o_s_ready registered: = (occupancy after this edge) < 2**FIFO_AW. Deasserts the cycle after the push that fills the FIFO; no push accepted while full.
- o_ce period = div_l+1 cycles; div_l=0 gives o_ce every cycle in RUN.
- PRIME -> RUN: first o_ce occurs div_l+1 cycles after entering RUN.
- All outputs registered. o_level counts with FIFO.
- Reset mid-operation: all state to reset values immediately (async), FIFO emptied.

## Test plan
- Reset: assert i_res mid-RUN -> o_ce=0, o_mod_res=1, o_func=0, o_level=0 without clock edge; o_s_ready=1 one cycle after release.
- Rate: i_ce_div=3, i_osr=3, push 0x10,0x20,0x30 then enable -> o_ce every 4 cycles; o_func 0x10 for 4 ticks, then 0x20, 0x30.
- Underrun: after last sample consumed, next boundary -> o_func=0, o_underrun=1; i_underrun_clr pulse clears; simultaneous underrun and clr leaves 1.
- Full: FIFO_AW=2, hold i_s_valid with i_enable=0 -> exactly 4 accepted, o_level=4, o_s_ready=0; one pop in RUN -> o_s_ready=1 next cycle.
- PRIME wait: enable with empty FIFO -> stays PRIME with o_mod_res=1, no o_ce; push 0x7F -> RUN, o_func=0x7F.
- Disable/config: i_enable=0 mid-sample -> IDLE next cycle, o_ce stops, FIFO level unchanged; change i_ce_div during RUN has no effect until next enable.
